// File: rtl/regfile_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface   : regfile_seq_if                                     |
// | Description : Command, register-file, stream-out and status      |
// |               signals of the register-file sequencer.            |
// |               master = environment side, slave = sequencer side. |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
interface regfile_seq_if;
  // Command channel
  logic        CmdValid;
  logic        CmdReady;
  logic [1:0]  CmdOp;
  logic [4:0]  CmdSrc;
  logic [4:0]  CmdDst;
  logic [5:0]  CmdCount;
  logic [31:0] CmdData;
  // Register-file port (sequencer is the register-file master)
  logic [4:0]  RfReadAddress1;
  logic [4:0]  RfReadAddress2;
  logic [4:0]  RfWriteAddress;
  logic [31:0] RfWriteData;
  logic        RfReadWriteEn;
  logic [31:0] RfReadData1;
  logic [31:0] RfReadData2;
  // Stream-out channel
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutData;
  logic [4:0]  OutAddr;
  // Status
  logic        Busy;
  logic        Done;
  logic        Err;

  modport master (
    output CmdValid, CmdOp, CmdSrc, CmdDst, CmdCount, CmdData,
    input  CmdReady,
    input  RfReadAddress1, RfReadAddress2, RfWriteAddress, RfWriteData, RfReadWriteEn,
    output RfReadData1, RfReadData2,
    input  OutValid, OutData, OutAddr,
    output OutReady,
    input  Busy, Done, Err
  );

  modport slave (
    input  CmdValid, CmdOp, CmdSrc, CmdDst, CmdCount, CmdData,
    output CmdReady,
    output RfReadAddress1, RfReadAddress2, RfWriteAddress, RfWriteData, RfReadWriteEn,
    input  RfReadData1, RfReadData2,
    output OutValid, OutData, OutAddr,
    input  OutReady,
    output Busy, Done, Err
  );
endinterface
`default_nettype wire

// File: rtl/regfile_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : regfile_seq                                        |
// | Description : Sequencer driving a 32x32 register file: FILL a    |
// |               range with a constant, COPY a range (pipelined,    |
// |               ascending-copy semantics) or DUMP a range to a     |
// |               valid/ready stream. SCRATCH is clobbered by COPY   |
// |               and DUMP.                                          |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module regfile_seq #(
  parameter logic [4:0] SCRATCH = 5'd31
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  regfile_seq_if.slave bus
);

  localparam logic [1:0] c_OP_FILL    = 2'b00;
  localparam logic [1:0] c_OP_COPY    = 2'b01;
  localparam logic [1:0] c_OP_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    COPY = 3'd2,
    DRD  = 3'd3,
    DOUT = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t      r_state;
  logic [4:0]  r_src;
  logic [4:0]  r_dst;
  logic [5:0]  r_cnt;
  logic [5:0]  r_idx;       // element (FILL/DUMP) or pipeline cycle (COPY)
  logic        r_cmd_ready;
  logic [4:0]  r_ra1;
  logic [4:0]  r_ra2;
  logic [4:0]  r_wa;
  logic [31:0] r_wd;
  logic        r_en;
  logic        r_wsel;      // COPY: write data comes from the read pipeline
  logic        r_fwd_v;     // read of this cycle collided with last write
  logic [31:0] r_fwd_d;
  logic        r_out_valid;
  logic [4:0]  r_out_addr;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic [5:0]  w_next;
  logic [31:0] w_rd1;

  assign w_next = r_idx + 6'd1;

  // The register file returns pre-write contents, so a read that hit the
  // address written in the same cycle is replaced by that written value.
  // This gives overlapping copies ascending element-by-element semantics.
  assign w_rd1 = r_fwd_v ? r_fwd_d : bus.RfReadData1;

  // Read data only exists one edge after the read is issued, so COPY write
  // data and DUMP stream data pass through muxes whose selects are registers.
  assign bus.RfWriteData    = r_wsel ? w_rd1 : r_wd;
  assign bus.OutData        = r_out_valid ? bus.RfReadData2 : 32'd0;

  assign bus.CmdReady       = r_cmd_ready;
  assign bus.RfReadAddress1 = r_ra1;
  assign bus.RfReadAddress2 = r_ra2;
  assign bus.RfWriteAddress = r_wa;
  assign bus.RfReadWriteEn  = r_en;
  assign bus.OutValid       = r_out_valid;
  assign bus.OutAddr        = r_out_addr;
  assign bus.Busy           = r_busy;
  assign bus.Done           = r_done;
  assign bus.Err            = r_err;

  // Sequencer FSM with all control outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_src       <= 5'd0;
      r_dst       <= 5'd0;
      r_cnt       <= 6'd0;
      r_idx       <= 6'd0;
      r_cmd_ready <= 1'b0;
      r_ra1       <= 5'd0;
      r_ra2       <= 5'd0;
      r_wa        <= 5'd0;
      r_wd        <= 32'd0;
      r_en        <= 1'b0;
      r_wsel      <= 1'b0;
      r_fwd_v     <= 1'b0;
      r_fwd_d     <= 32'd0;
      r_out_valid <= 1'b0;
      r_out_addr  <= 5'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (bus.CmdValid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_src       <= bus.CmdSrc;
            r_dst       <= bus.CmdDst;
            r_cnt       <= bus.CmdCount;
            r_idx       <= 6'd0;
            r_wsel      <= 1'b0;
            r_fwd_v     <= 1'b0;
            if (bus.CmdOp == c_OP_ILLEGAL || bus.CmdCount == 6'd0) begin
              // Nothing to touch in the register file.
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= (bus.CmdOp == c_OP_ILLEGAL);
            end else begin
              r_en <= 1'b1;
              case (bus.CmdOp)
                c_OP_FILL: begin
                  r_state <= FILL;
                  r_ra1   <= SCRATCH;
                  r_ra2   <= SCRATCH;
                  r_wa    <= bus.CmdDst;
                  r_wd    <= bus.CmdData;
                end
                c_OP_COPY: begin
                  // Cycle 0 primes the read pipeline; its write lands on SCRATCH.
                  r_state <= COPY;
                  r_ra1   <= bus.CmdSrc;
                  r_ra2   <= SCRATCH;
                  r_wa    <= SCRATCH;
                  r_wd    <= 32'd0;
                end
                default: begin
                  r_state <= DRD;
                  r_ra1   <= SCRATCH;
                  r_ra2   <= bus.CmdSrc;
                  r_wa    <= SCRATCH;
                  r_wd    <= 32'd0;
                end
              endcase
            end
          end
        end

        FILL: begin
          if (w_next == r_cnt) begin
            r_en    <= 1'b0;
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx <= w_next;
            r_wa  <= r_dst + w_next[4:0];
          end
        end

        COPY: begin
          r_fwd_v <= r_wsel && (r_ra1 == r_wa);
          r_fwd_d <= w_rd1;
          if (r_idx == r_cnt) begin
            r_en    <= 1'b0;
            r_wsel  <= 1'b0;
            r_fwd_v <= 1'b0;
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            // Next cycle reads element idx+1 (SCRATCH after the last) and
            // writes element idx with the data read this cycle.
            r_idx  <= w_next;
            r_ra1  <= (w_next == r_cnt) ? SCRATCH : (r_src + w_next[4:0]);
            r_wa   <= r_dst + r_idx[4:0];
            r_wsel <= 1'b1;
          end
        end

        DRD: begin
          r_en        <= 1'b0;
          r_state     <= DOUT;
          r_out_valid <= 1'b1;
          r_out_addr  <= r_ra2;
        end

        DOUT: begin
          if (bus.OutReady) begin
            r_out_valid <= 1'b0;
            if (w_next == r_cnt) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= w_next;
              r_state <= DRD;
              r_en    <= 1'b1;
              r_ra2   <= r_src + w_next[4:0];
            end
          end
        end

        DONE: begin
          r_done      <= 1'b0;
          r_err       <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_regfile_seq                                     |
// | Description : Self-checking bench for regfile_seq with a         |
// |               behavioural register file and a scoreboard of      |
// |               expected writes and stream beats.                  |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_regfile_seq;

  typedef struct packed {
    logic        chk;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ad_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_seq_if bus();

  regfile_seq #(.SCRATCH(5'd31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural register file: write plus registered pre-write reads on enable.
  logic [31:0] mem [32];
  logic [31:0] rd1_q   = 32'd0;
  logic [31:0] rd2_q   = 32'd0;
  logic        pre_go  = 1'b0;
  logic [31:0] pre_xor = 32'd0;

  always @(posedge clk) begin
    if (pre_go) begin
      for (int i = 0; i < 32; i++) mem[i] <= i[31:0] ^ pre_xor;
    end else if (bus.RfReadWriteEn) begin
      rd1_q <= mem[bus.RfReadAddress1];
      rd2_q <= mem[bus.RfReadAddress2];
      mem[bus.RfWriteAddress] <= bus.RfWriteData;
    end
  end
  assign bus.RfReadData1 = rd1_q;
  assign bus.RfReadData2 = rd2_q;

  logic [31:0] ref_mem [32];
  exp_t exp_w[$];
  ad_t  exp_b[$];
  ad_t  obs_w[$];
  ad_t  obs_b[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   first_en, done_cyc, n_done, unstable;
  logic err_at_done, rdy_at_done;
  bit   tmo;

  task automatic preload(input logic [31:0] x);
    @(negedge clk);
    pre_go  = 1'b1;
    pre_xor = x;
    for (int i = 0; i < 32; i++) ref_mem[i] = i[31:0] ^ x;
    @(negedge clk);
    pre_go = 1'b0;
  endtask

  // Issue one command and record writes, stream beats and status until Done.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] src, input logic [4:0] dst,
                         input logic [5:0] cnt, input logic [31:0] data, input int stall);
    int cyc;
    int st;
    bit pv, phs;
    ad_t pbeat;
    obs_w.delete(); obs_b.delete();
    first_en = -1; done_cyc = -1; n_done = 0; unstable = 0;
    err_at_done = 1'b0; rdy_at_done = 1'b0; tmo = 1'b0;
    pv = 1'b0; phs = 1'b0; st = 0; pbeat = '0;
    @(negedge clk);
    bus.CmdOp = op; bus.CmdSrc = src; bus.CmdDst = dst;
    bus.CmdCount = cnt; bus.CmdData = data; bus.CmdValid = 1'b1;
    cyc = 0;
    while (!bus.CmdReady && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    bus.CmdValid = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      if (bus.RfReadWriteEn) begin
        obs_w.push_back({bus.RfWriteAddress, bus.RfWriteData});
        if (first_en < 0) first_en = cyc;
      end
      if (bus.OutValid) begin
        if (pv && !phs && ({bus.OutAddr, bus.OutData} != pbeat)) unstable++;
        pbeat = {bus.OutAddr, bus.OutData};
        pv = 1'b1;
        if (st < stall) begin
          bus.OutReady = 1'b0; st++; phs = 1'b0;
        end else begin
          bus.OutReady = 1'b1; st = 0; phs = 1'b1;
          obs_b.push_back(pbeat);
        end
      end else begin
        bus.OutReady = 1'b0; pv = 1'b0; phs = 1'b0;
      end
      if (bus.Done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc; err_at_done = bus.Err; rdy_at_done = bus.CmdReady;
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
      cyc++;
    end
    bus.OutReady = 1'b0;
    if (done_cyc < 0) tmo = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_total++; if (bus.CmdReady !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.CmdReady); else n_pass++;
    n_total++; if (bus.Busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.Busy); else n_pass++;
    n_total++; if (bus.RfReadWriteEn !== 1'b0) $display("FAIL rst_en: got %b want 0", bus.RfReadWriteEn); else n_pass++;
    n_total++; if ({bus.Done, bus.Err, bus.OutValid} !== 3'b000) $display("FAIL rst_status: got %b want 000", {bus.Done, bus.Err, bus.OutValid}); else n_pass++;
    n_total++; if ({bus.OutData, bus.RfWriteData} !== 64'd0) $display("FAIL rst_data: got %h want 0", {bus.OutData, bus.RfWriteData}); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (bus.CmdReady !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", bus.CmdReady); else n_pass++;
  endtask

  task automatic test_fill;
    exp_t e;
    ad_t  o;
    logic [4:0] a;
    int bad;
    for (int i = 0; i < 4; i++) begin
      a = 5'd30 + i[4:0];
      exp_w.push_back({1'b1, a, 32'hA5A5_0001});
      ref_mem[a] = 32'hA5A5_0001;
    end
    run_cmd(2'b00, 5'd0, 5'd30, 6'd4, 32'hA5A5_0001, 0);
    n_total++; if (tmo !== 1'b0) $display("FAIL fill_timeout: no Done seen"); else n_pass++;
    n_total++; if (obs_w.size() !== 4) $display("FAIL fill_en_cycles: got %0d want 4", obs_w.size()); else n_pass++;
    n_total++; if (first_en !== 1) $display("FAIL fill_first_en: got cycle %0d want 1", first_en); else n_pass++;
    n_total++; if (done_cyc !== 5 || n_done !== 1) $display("FAIL fill_done: got cycle %0d x%0d want cycle 5 x1", done_cyc, n_done); else n_pass++;
    n_total++; if (err_at_done !== 1'b0 || rdy_at_done !== 1'b0) $display("FAIL fill_err_ready: got err=%b rdy=%b want 0 0", err_at_done, rdy_at_done); else n_pass++;
    while (exp_w.size() > 0) begin
      e = exp_w.pop_front();
      n_total++;
      if (obs_w.size() == 0) $display("FAIL fill_write: missing write to %0d", e.a);
      else begin
        o = obs_w.pop_front();
        if (o.a !== e.a || (e.chk && o.d !== e.d)) $display("FAIL fill_write: got %0d<=%h want %0d<=%h", o.a, o.d, e.a, e.d);
        else n_pass++;
      end
    end
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_total++; if (bad !== 0) $display("FAIL fill_mem: got %0d wrong registers want 0", bad); else n_pass++;
  endtask

  task automatic test_copy(input string nm, input logic [4:0] src, input logic [4:0] dst, input logic [5:0] cnt);
    exp_t e;
    ad_t  o;
    logic [4:0] da, sa;
    int bad;
    preload(32'd0);
    exp_w.push_back({1'b0, 5'd31, 32'd0});
    for (int i = 0; i < int'(cnt); i++) begin
      sa = src + i[4:0];
      da = dst + i[4:0];
      ref_mem[da] = ref_mem[sa];
      exp_w.push_back({1'b1, da, ref_mem[da]});
    end
    run_cmd(2'b01, src, dst, cnt, 32'd0, 0);
    n_total++; if (tmo !== 1'b0) $display("FAIL %s_timeout: no Done seen", nm); else n_pass++;
    n_total++; if (obs_w.size() !== int'(cnt) + 1) $display("FAIL %s_en_cycles: got %0d want %0d", nm, obs_w.size(), int'(cnt) + 1); else n_pass++;
    n_total++; if (first_en !== 1 || done_cyc !== int'(cnt) + 2 || n_done !== 1) $display("FAIL %s_timing: got en@%0d done@%0d x%0d want en@1 done@%0d x1", nm, first_en, done_cyc, n_done, int'(cnt) + 2); else n_pass++;
    while (exp_w.size() > 0) begin
      e = exp_w.pop_front();
      n_total++;
      if (obs_w.size() == 0) $display("FAIL %s_write: missing write to %0d", nm, e.a);
      else begin
        o = obs_w.pop_front();
        if (o.a !== e.a || (e.chk && o.d !== e.d)) $display("FAIL %s_write: got %0d<=%h want %0d<=%h", nm, o.a, o.d, e.a, e.d);
        else n_pass++;
      end
    end
    bad = 0;
    for (int i = 0; i < 31; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_total++; if (bad !== 0) $display("FAIL %s_mem: got %0d wrong registers want 0", nm, bad); else n_pass++;
  endtask

  task automatic test_dump;
    exp_t e;
    ad_t  o, eb;
    preload(32'h5A00_0000);
    for (int i = 0; i < 2; i++) begin
      exp_w.push_back({1'b1, 5'd31, 32'd0});
      exp_b.push_back({5'd8 + i[4:0], ref_mem[8 + i]});
    end
    ref_mem[31] = 32'd0;
    run_cmd(2'b10, 5'd8, 5'd0, 6'd2, 32'd0, 3);
    n_total++; if (tmo !== 1'b0) $display("FAIL dump_timeout: no Done seen"); else n_pass++;
    n_total++; if (unstable !== 0) $display("FAIL dump_stable: got %0d changes under stall want 0", unstable); else n_pass++;
    n_total++; if (done_cyc !== 11 || n_done !== 1 || err_at_done !== 1'b0) $display("FAIL dump_done: got cycle %0d x%0d err=%b want cycle 11 x1 err=0", done_cyc, n_done, err_at_done); else n_pass++;
    n_total++; if (obs_w.size() !== 2) $display("FAIL dump_en_cycles: got %0d want 2", obs_w.size()); else n_pass++;
    while (exp_b.size() > 0) begin
      eb = exp_b.pop_front();
      n_total++;
      if (obs_b.size() == 0) $display("FAIL dump_beat: missing beat addr %0d", eb.a);
      else begin
        o = obs_b.pop_front();
        if (o !== eb) $display("FAIL dump_beat: got (%h,%0d) want (%h,%0d)", o.d, o.a, eb.d, eb.a);
        else n_pass++;
      end
    end
    while (exp_w.size() > 0) begin
      e = exp_w.pop_front();
      n_total++;
      if (obs_w.size() == 0) $display("FAIL dump_write: missing write to %0d", e.a);
      else begin
        o = obs_w.pop_front();
        if (o.a !== e.a || o.d !== e.d) $display("FAIL dump_write: got %0d<=%h want %0d<=%h", o.a, o.d, e.a, e.d);
        else n_pass++;
      end
    end
  endtask

  task automatic test_no_work;
    run_cmd(2'b11, 5'd0, 5'd0, 6'd5, 32'd0, 0);
    n_total++; if (obs_w.size() !== 0 || tmo !== 1'b0) $display("FAIL illegal_en: got %0d en cycles tmo=%b want 0 0", obs_w.size(), tmo); else n_pass++;
    n_total++; if (done_cyc !== 1 || n_done !== 1 || err_at_done !== 1'b1) $display("FAIL illegal_done: got cycle %0d x%0d err=%b want cycle 1 x1 err=1", done_cyc, n_done, err_at_done); else n_pass++;
    run_cmd(2'b00, 5'd0, 5'd3, 6'd0, 32'hFFFF_FFFF, 0);
    n_total++; if (obs_w.size() !== 0 || tmo !== 1'b0) $display("FAIL count0_en: got %0d en cycles tmo=%b want 0 0", obs_w.size(), tmo); else n_pass++;
    n_total++; if (done_cyc !== 1 || n_done !== 1 || err_at_done !== 1'b0) $display("FAIL count0_done: got cycle %0d x%0d err=%b want cycle 1 x1 err=0", done_cyc, n_done, err_at_done); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [5:0] en_mask, done_mask;
    en_mask = '0; done_mask = '0;
    @(negedge clk);
    bus.CmdOp = 2'b00; bus.CmdDst = 5'd3; bus.CmdCount = 6'd1;
    bus.CmdData = 32'h1234_5678; bus.CmdValid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      en_mask[k-1]   = bus.RfReadWriteEn;
      done_mask[k-1] = bus.Done;
      if (k == 6) bus.CmdValid = 1'b0;
    end
    ref_mem[3] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    n_total++; if (en_mask !== 6'b001001) $display("FAIL b2b_en: got %b want 001001", en_mask); else n_pass++;
    n_total++; if (done_mask !== 6'b010010) $display("FAIL b2b_done: got %b want 010010", done_mask); else n_pass++;
    n_total++; if (mem[3] !== 32'h1234_5678) $display("FAIL b2b_mem: got %h want 12345678", mem[3]); else n_pass++;
  endtask

  task automatic test_reset_abort;
    int k;
    int bad;
    @(negedge clk);
    bus.CmdOp = 2'b00; bus.CmdDst = 5'd20; bus.CmdCount = 6'd8;
    bus.CmdData = 32'hDEAD_BEEF; bus.CmdValid = 1'b1;
    k = 0;
    while (!bus.CmdReady && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    bus.CmdValid = 1'b0;
    n_total++; if (bus.RfReadWriteEn !== 1'b1) $display("FAIL abort_en1: got %b want 1", bus.RfReadWriteEn); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.RfReadWriteEn !== 1'b1) $display("FAIL abort_en2: got %b want 1", bus.RfReadWriteEn); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_total++; if ({bus.RfReadWriteEn, bus.Busy, bus.Done, bus.CmdReady} !== 4'b0000) $display("FAIL abort_state: got en,busy,done,rdy=%b want 0000", {bus.RfReadWriteEn, bus.Busy, bus.Done, bus.CmdReady}); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (bus.CmdReady !== 1'b1) $display("FAIL abort_ready: got %b want 1", bus.CmdReady); else n_pass++;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.Done !== 1'b0 || bus.RfReadWriteEn !== 1'b0) bad++;
      @(negedge clk);
    end
    n_total++; if (bad !== 0) $display("FAIL abort_quiet: got %0d cycles with Done/en want 0", bad); else n_pass++;
    n_total++; if ({mem[20], mem[21], mem[22]} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF, ref_mem[22]})
      $display("FAIL abort_mem: got %h %h %h want deadbeef deadbeef %h", mem[20], mem[21], mem[22], ref_mem[22]); else n_pass++;
  endtask

  initial begin
    bus.CmdValid = 1'b0; bus.CmdOp = 2'b00; bus.CmdSrc = 5'd0; bus.CmdDst = 5'd0;
    bus.CmdCount = 6'd0; bus.CmdData = 32'd0; bus.OutReady = 1'b0;
    preload(32'd0);
    test_reset;
    test_fill;
    test_copy("copy", 5'd2, 5'd10, 6'd3);
    test_copy("overlap", 5'd4, 5'd5, 6'd3);
    test_dump;
    test_no_work;
    test_back_to_back;
    test_reset_abort;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
